mem_lsu: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register; it consumes the registered memory-op controls, address and store data and turns them into transactions on a valid/ready data-memory bus. It issues byte-lane-correct stores, aligns and extends load data, and stalls the pipeline until each access completes.

---
 rtl/lsu_pkg.sv | 61 ++++++
 rtl/lsu_load_align.sv | 37 +++
 rtl/mem_lsu.sv | 99 +++++++++
 tb/tb_mem_lsu.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Covers FSM states, funct3 size codes and byte-lane helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RSP,
      DONE
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // size[1:0] encodes access width for both signed and unsigned loads
   function automatic logic lsu_misaligned(
      input logic [2:0] size,
      input logic [1:0] off
   );
      logic m;
      m = 1'b0;
      unique case (size[1:0])
         2'b01:   m = off[0];
         2'b10:   m = |off;
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [3:0] lsu_be(
      input logic [2:0] size,
      input logic [1:0] off
   );
      logic [3:0] be;
      be = 4'b1111;
      unique case (size[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lsu_wdata(
      input logic [2:0]  size,
      input logic [31:0] data
   );
      logic [31:0] w;
      w = data;
      unique case (size[1:0])
         2'b00:   w = {4{data[7:0]}};
         2'b01:   w = {2{data[15:0]}};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half from a raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  size_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      unique case (off_i)
         2'd0:    byte_sel = rdata_i[7:0];
         2'd1:    byte_sel = rdata_i[15:8];
         2'd2:    byte_sel = rdata_i[23:16];
         default: byte_sel = rdata_i[31:24];
      endcase
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = rdata_i;
      unique case (size_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives a valid/ready data bus,
// stalls the pipeline per access and returns aligned load data.
module mem_lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid_mem_i,
   input  logic        dram_we_mem_i,
   input  logic        dram_re_mem_i,
   input  logic [2:0]  size_mem_i,
   input  logic [31:0] alu_result_mem_i,
   input  logic [31:0] rD2_mem_i,
   output logic        req_valid_o,
   input  logic        req_ready_i,
   output logic        req_we_o,
   output logic [31:0] req_addr_o,
   output logic [3:0]  req_be_o,
   output logic [31:0] req_wdata_o,
   input  logic        rsp_valid_i,
   input  logic [31:0] rsp_rdata_i,
   output logic        lsu_stall_o,
   output logic [31:0] load_data_o,
   output logic        load_valid_o,
   output logic        misaligned_o
);

   lsu_state_e  state_q, state_d;
   logic        mem_op, mis, go;
   logic        we_q;
   logic [1:0]  off_q;
   logic [2:0]  size_q;
   logic [31:0] align_data;

   assign mem_op = instr_valid_mem_i & (dram_we_mem_i | dram_re_mem_i);
   assign mis    = lsu_misaligned(size_mem_i, alu_result_mem_i[1:0]);
   assign go     = mem_op & ~mis;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (go) state_d = REQ;
         REQ:     if (req_ready_i) state_d = we_q ? DONE : RSP;
         RSP:     if (rsp_valid_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // DONE releases the stall so EX/MEM advances on that edge
   assign lsu_stall_o  = ((state_q == IDLE) & go) |
                         (state_q == REQ) | (state_q == RSP);
   assign misaligned_o = (state_q == IDLE) & mem_op & mis;
   assign load_valid_o = (state_q == DONE) & ~we_q;

   lsu_load_align u_align (
      .rdata_i (rsp_rdata_i),
      .off_i   (off_q),
      .size_i  (size_q),
      .data_o  (align_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_valid_o <= 1'b0;
         req_we_o    <= 1'b0;
         req_addr_o  <= '0;
         req_be_o    <= '0;
         req_wdata_o <= '0;
         we_q        <= 1'b0;
         off_q       <= '0;
         size_q      <= '0;
         load_data_o <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && go) begin
            req_valid_o <= 1'b1;
            req_we_o    <= dram_we_mem_i;
            req_addr_o  <= {alu_result_mem_i[31:2], 2'b00};
            req_be_o    <= lsu_be(size_mem_i, alu_result_mem_i[1:0]);
            req_wdata_o <= lsu_wdata(size_mem_i, rD2_mem_i);
            we_q        <= dram_we_mem_i;
            off_q       <= alu_result_mem_i[1:0];
            size_q      <= size_mem_i;
         end
         if (state_q == REQ && req_ready_i) begin
            req_valid_o <= 1'b0;
            req_we_o    <= 1'b0;
            req_addr_o  <= '0;
            req_be_o    <= '0;
            req_wdata_o <= '0;
         end
         if (state_q == RSP && rsp_valid_i)
            load_data_o <= align_data;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: randomized loads/stores with bus waits,
// a reference model of lane/extension rules, and reset-abort scenarios.
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid_mem_i, dram_we_mem_i, dram_re_mem_i;
   logic [2:0]  size_mem_i;
   logic [31:0] alu_result_mem_i, rD2_mem_i;
   logic        req_valid_o, req_ready_i, req_we_o;
   logic [31:0] req_addr_o, req_wdata_o;
   logic [3:0]  req_be_o;
   logic        rsp_valid_i;
   logic [31:0] rsp_rdata_i;
   logic        lsu_stall_o, load_valid_o, misaligned_o;
   logic [31:0] load_data_o;

   logic [31:0] al_w, al_res;
   logic [1:0]  al_off;
   logic [2:0]  al_size;

   always #5 clk = ~clk;

   mem_lsu dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instr_valid_mem_i (instr_valid_mem_i),
      .dram_we_mem_i     (dram_we_mem_i),
      .dram_re_mem_i     (dram_re_mem_i),
      .size_mem_i        (size_mem_i),
      .alu_result_mem_i  (alu_result_mem_i),
      .rD2_mem_i         (rD2_mem_i),
      .req_valid_o       (req_valid_o),
      .req_ready_i       (req_ready_i),
      .req_we_o          (req_we_o),
      .req_addr_o        (req_addr_o),
      .req_be_o          (req_be_o),
      .req_wdata_o       (req_wdata_o),
      .rsp_valid_i       (rsp_valid_i),
      .rsp_rdata_i       (rsp_rdata_i),
      .lsu_stall_o       (lsu_stall_o),
      .load_data_o       (load_data_o),
      .load_valid_o      (load_valid_o),
      .misaligned_o      (misaligned_o)
   );

   lsu_load_align u_al (
      .rdata_i (al_w),
      .off_i   (al_off),
      .size_i  (al_size),
      .data_o  (al_res)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } req_t;

   req_t        req_q[$];
   logic [31:0] load_q[$];
   int          mis_q[$];

   int          checks = 0;
   int          failures = 0;
   int          ready_wait = 0;
   int          rsp_wait = 0;
   logic [31:0] rsp_word = '0;
   bit          in_rsp = 0;
   int          rcnt = 0;
   int          scnt = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: access width in bytes drives every rule
   function automatic int m_bytes(input logic [2:0] sz);
      return 1 << sz[1:0];
   endfunction

   function automatic bit m_mis(input logic [2:0] sz, input logic [31:0] a);
      return (a % m_bytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] sz,
                                       input logic [31:0] a);
      int n;
      n = m_bytes(sz);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] sz,
                                           input logic [31:0] d);
      logic [31:0] w;
      int n;
      n = m_bytes(sz);
      for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w,
                                          input logic [1:0] off,
                                          input logic [2:0] sz);
      logic [31:0] sh;
      sh = w >> (8 * int'(off));
      case (sz)
         3'b000:  return 32'($signed(sh[7:0]));
         3'b001:  return 32'($signed(sh[15:0]));
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   // Bus model: waits per transaction, junk responses when idle
   initial begin
      req_ready_i = 1'b0;
      rsp_valid_i = 1'b0;
      rsp_rdata_i = '0;
      forever begin
         @(posedge clk);
         #2;
         req_ready_i = 1'b0;
         rsp_valid_i = 1'b0;
         if (in_rsp) begin
            if (scnt < rsp_wait) scnt++;
            else begin
               rsp_valid_i = 1'b1;
               rsp_rdata_i = rsp_word;
               in_rsp = 0;
               scnt = 0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            rsp_valid_i = 1'b1;
            rsp_rdata_i = $urandom;
         end
         if (req_valid_o) begin
            if (rcnt < ready_wait) rcnt++;
            else begin
               req_ready_i = 1'b1;
               rcnt = 0;
               if (!req_we_o) in_rsp = 1;
            end
         end else begin
            req_ready_i = 1'($urandom_range(0, 1));
         end
      end
   end

   // Monitor: compares every presented output against the queues
   initial begin
      req_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (req_valid_o) begin
               if (req_q.size() == 0) chk("unexpected_req", 1, 0);
               else begin
                  e = req_q[0];
                  chk("req_we", 32'(req_we_o), 32'(e.we));
                  chk("req_addr", req_addr_o, e.addr);
                  chk("req_be", 32'(req_be_o), 32'(e.be));
                  if (e.we) chk("req_wdata", req_wdata_o, e.wdata);
                  if (req_ready_i) void'(req_q.pop_front());
               end
            end
            if (load_valid_o) begin
               if (load_q.size() == 0) chk("unexpected_load_valid", 1, 0);
               else chk("load_data", load_data_o, load_q.pop_front());
            end
            if (misaligned_o) begin
               if (mis_q.size() == 0) chk("unexpected_misaligned", 1, 0);
               else begin
                  chk("mis_no_req", 32'(req_valid_o), 0);
                  void'(mis_q.pop_front());
               end
            end
         end
      end
   end

   task automatic idle_inputs();
      instr_valid_mem_i = 1'b0;
      dram_we_mem_i     = 1'b0;
      dram_re_mem_i     = 1'b0;
   endtask

   task automatic do_op(input bit we, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] d,
                        input int rw, input int sw,
                        input logic [31:0] word);
      bit mis;
      int st, exp_st;
      req_t r;
      mis = m_mis(sz, addr);
      ready_wait = rw;
      rsp_wait = sw;
      rsp_word = word;
      if (mis) mis_q.push_back(1);
      else begin
         r.we = we;
         r.addr = addr & 32'hFFFF_FFFC;
         r.be = m_be(sz, addr);
         r.wdata = m_wdata(sz, d);
         req_q.push_back(r);
         if (!we) load_q.push_back(m_load(word, addr[1:0], sz));
      end
      instr_valid_mem_i = 1'b1;
      dram_we_mem_i     = we;
      dram_re_mem_i     = !we;
      size_mem_i        = sz;
      alu_result_mem_i  = addr;
      rD2_mem_i         = d;
      st = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!lsu_stall_o) break;
         st++;
         @(posedge clk);
         #1;
      end
      exp_st = mis ? 0 : (we ? 2 + rw : 3 + rw + sw);
      chk("stall_cycles", st, exp_st);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic start_op_raw(input logic [31:0] addr, input int rw,
                               input int sw);
      req_t r;
      ready_wait = rw;
      rsp_wait = sw;
      rsp_word = 32'hCAFE_F00D;
      r.we = 1'b0;
      r.addr = addr;
      r.be = 4'hF;
      r.wdata = '0;
      req_q.push_back(r);
      load_q.push_back(32'hCAFE_F00D);
      instr_valid_mem_i = 1'b1;
      dram_we_mem_i     = 1'b0;
      dram_re_mem_i     = 1'b1;
      size_mem_i        = 3'b010;
      alu_result_mem_i  = addr;
      rD2_mem_i         = '0;
   endtask

   logic [2:0] ld_sizes[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      size_mem_i = '0;
      alu_result_mem_i = '0;
      rD2_mem_i = '0;
      al_w = '0;
      al_off = '0;
      al_size = '0;
      #12;
      chk("rst_req_valid", 32'(req_valid_o), 0);
      chk("rst_req_we", 32'(req_we_o), 0);
      chk("rst_req_addr", req_addr_o, 0);
      chk("rst_req_be", 32'(req_be_o), 0);
      chk("rst_req_wdata", req_wdata_o, 0);
      chk("rst_load_data", load_data_o, 0);
      chk("rst_load_valid", 32'(load_valid_o), 0);
      chk("rst_misaligned", 32'(misaligned_o), 0);
      chk("rst_stall", 32'(lsu_stall_o), 0);

      for (int i = 0; i < 40; i++) begin
         al_w = $urandom;
         al_size = ld_sizes[$urandom_range(0, 4)];
         al_off = 2'($urandom_range(0, 3));
         if (al_size[1:0] == 2'b01) al_off[0] = 1'b0;
         if (al_size[1:0] == 2'b10) al_off = 2'b00;
         #1;
         chk("align_unit", al_res, m_load(al_w, al_off, al_size));
      end

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_op(0, 3'b010, 32'h100, 0, 0, 0, 32'hDEAD_BEEF);
      do_op(0, 3'b000, 32'h103, 0, 0, 0, 32'h80FF_0000);
      do_op(0, 3'b100, 32'h103, 0, 0, 0, 32'h80FF_0000);
      do_op(1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 0, 0);
      do_op(0, 3'b010, 32'h104, 0, 3, 2, 32'h1357_9BDF);
      do_op(0, 3'b001, 32'h301, 0, 0, 0, 0);
      chk("load_data_hold", load_data_o, 32'h1357_9BDF);

      start_op_raw(32'h400, 10, 0);
      @(negedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_req_drop_valid", 32'(req_valid_o), 0);
      chk("rst_req_drop_addr", req_addr_o, 0);
      chk("rst_req_drop_stall", 32'(lsu_stall_o), 0);
      void'(req_q.pop_front());
      void'(load_q.pop_back());
      rcnt = 0;
      in_rsp = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      start_op_raw(32'h500, 0, 4);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 32'(req_valid_o), 0);
      chk("rst_rsp_load_valid", 32'(load_valid_o), 0);
      chk("rst_rsp_stall", 32'(lsu_stall_o), 0);
      chk("rst_rsp_load_data", load_data_o, 0);
      void'(load_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("late_rsp_no_data", load_data_o, 0);
      in_rsp = 0;

      for (int n = 0; n < 150; n++) begin
         bit we;
         logic [2:0] sz;
         logic [31:0] a;
         we = 1'($urandom_range(0, 1));
         sz = we ? 3'($urandom_range(0, 2)) : ld_sizes[$urandom_range(0, 4)];
         a = $urandom;
         if ($urandom_range(0, 3) != 0)
            a = a & ~32'(m_bytes(sz) - 1);
         do_op(we, sz, a, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("req_q_drained", req_q.size(), 0);
      chk("load_q_drained", load_q.size(), 0);
      chk("mis_q_drained", mis_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
